// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: the fetch
// state encoding, the NOP word, the default PC increment and the IF/ID
// bundle that travels from fetch into decode.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_WORD = 32'd4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } ifid_t;

    // Builds a valid IF/ID record for a fetched word; pc4 wraps modulo 2^32.
    function automatic ifid_t make_ifid(input logic [31:0] pc,
                                        input logic [31:0] step,
                                        input logic [31:0] instr);
        ifid_t rec;
        rec.valid = 1'b1;
        rec.pc    = pc;
        rec.pc4   = pc + step;
        rec.instr = instr;
        return rec;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus. The fetch stage is the
// master (drives request and address); instruction memory is the slave.
interface if_fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_stage_hold_buf.sv
// if_hold_buf: single-entry holding buffer that parks a fetched IF/ID
// record while decode is stalled. Clear wins over load.
module if_hold_buf
    import if_fetch_stage_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  load,
    input  logic  clear,
    input  ifid_t din,
    output ifid_t dout,
    output logic  valid
);

    ifid_t entry_q;
    logic  valid_q;

    // Capture a record on load, drop it on clear, empty out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entry_q <= '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, instr: NOP_WORD};
            valid_q <= 1'b0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            entry_q <= din;
            valid_q <= 1'b1;
        end
    end

    assign dout  = entry_q;
    assign valid = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage between the PC register and the
// IF/ID pipeline register. Runs one outstanding req/ack transaction at a
// time, parks a word in a holding buffer while decode stalls, and squashes
// on branch/jump flush (an in-flight request is drained in DROP).
// Optional build macro IF_FETCH_PERF_CNT_EN adds fetch/stall counters.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_WORD,
    parameter logic [31:0] PC_STEP   = PC_STEP_WORD
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             pc_in,
    input  logic                    flush,
    input  logic                    id_stall,
    if_fetch_stage_if.master        imem,
    output logic                    if_stall,
    output logic                    id_valid,
    output logic [31:0]             id_pc,
    output logic [31:0]             id_pc4,
    output logic [31:0]             id_instr
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             perf_fetch_cnt,
    output logic [31:0]             perf_stall_cnt
`endif
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  addr_q;
    ifid_t        ifid_q;
    ifid_t        ifid_d;
    ifid_t        fetched;
    ifid_t        hold_dout;
    logic         hold_valid;
    logic         hold_load;
    logic         hold_clear;
    logic         req_c;
    logic [31:0]  addr_c;
    logic         stall_c;

    assign fetched = make_ifid(pc_in, PC_STEP, imem.imem_rdata);

    if_hold_buf u_hold_buf (
        .clock (clock),
        .reset (reset),
        .load  (hold_load),
        .clear (hold_clear),
        .din   (fetched),
        .dout  (hold_dout),
        .valid (hold_valid)
    );

    // Next-state, memory request and IF/ID update; flush overrides the rest.
    always_comb begin
        state_d    = state_q;
        ifid_d     = ifid_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        req_c      = 1'b0;
        addr_c     = addr_q;
        stall_c    = 1'b1;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                req_c  = 1'b1;
                addr_c = pc_in;
                if (imem.imem_ack && !id_stall) begin
                    ifid_d  = fetched;
                    stall_c = 1'b0;
                end else if (imem.imem_ack) begin
                    hold_load = 1'b1;
                    state_d   = HOLD;
                end else if (!id_stall) begin
                    ifid_d.valid = 1'b0;
                    ifid_d.instr = NOP_INSTR;
                end
            end
            HOLD: begin
                if (!id_stall && hold_valid) begin
                    ifid_d     = hold_dout;
                    hold_clear = 1'b1;
                    stall_c    = 1'b0;
                    state_d    = REQ;
                end
            end
            DROP: begin
                req_c  = 1'b1;
                addr_c = addr_q;
                if (imem.imem_ack) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            ifid_d       = ifid_q;
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
            hold_load    = 1'b0;
            hold_clear   = 1'b1;
            stall_c      = 1'b0;
            case (state_q)
                REQ:     state_d = imem.imem_ack ? REQ : DROP;
                DROP:    state_d = DROP;
                default: state_d = REQ;
            endcase
        end
    end

    // Fetch state, in-flight address and the IF/ID register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            ifid_q  <= '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR};
        end else begin
            state_q <= state_d;
            ifid_q  <= ifid_d;
            if (state_q == REQ) begin
                addr_q <= pc_in;
            end
        end
    end

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = addr_c;
    assign if_stall       = stall_c;
    assign id_valid       = ifid_q.valid;
    assign id_pc          = ifid_q.pc;
    assign id_pc4         = ifid_q.pc4;
    assign id_instr       = ifid_q.instr;

`ifdef IF_FETCH_PERF_CNT_EN
    logic fetch_inc;
    logic stall_inc;

    assign fetch_inc = !flush &&
                       (((state_q == REQ) && imem.imem_ack && !id_stall) ||
                        ((state_q == HOLD) && hold_valid && !id_stall));
    assign stall_inc = stall_c && (state_q != IDLE);

    // Free-running performance counters for delivered fetches and stall cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
        end else begin
            if (fetch_inc) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stall_inc) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed per-cycle vectors, a
// transaction-level model of the fetch stage and the PC register, and
// hand-computed literal checks at key points of the sequence.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic        flush = 1'b0;
    logic        id_stall = 1'b0;
    logic        if_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    if_fetch_stage_if imem ();

    if_fetch_stage dut (
        .clock    (clock),
        .reset    (reset),
        .pc_in    (pc_in),
        .flush    (flush),
        .id_stall (id_stall),
        .imem     (imem),
        .if_stall (if_stall),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_pc4   (id_pc4),
        .id_instr (id_instr)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } rec_t;

    bit          m_idle;
    bit          m_discard;
    logic [31:0] m_old_addr;
    rec_t        held[$];
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc_reg;
    int unsigned m_fetch_cnt;
    int unsigned m_stall_cnt;
    logic [31:0] tgt;

    bit          e_req;
    bit          e_stall;
    logic [31:0] e_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_300C) return 32'h2408_0005;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset(input logic [31:0] start_pc);
        m_idle      = 1'b1;
        m_discard   = 1'b0;
        m_old_addr  = 32'h0;
        held.delete();
        m_valid     = 1'b0;
        m_pc        = 32'h0;
        m_instr     = NOP_WORD;
        m_pc_reg    = start_pc;
        m_fetch_cnt = 0;
        m_stall_cnt = 0;
    endtask

    task automatic compute_expected();
        e_addr = 32'h0;
        if (m_idle) begin
            e_req   = 1'b0;
            e_stall = !flush;
        end else if (held.size() != 0) begin
            e_req   = 1'b0;
            e_stall = !(flush || !id_stall);
        end else if (m_discard) begin
            e_req   = 1'b1;
            e_addr  = m_old_addr;
            e_stall = !flush;
        end else begin
            e_req   = 1'b1;
            e_addr  = pc_in;
            e_stall = !(flush || (imem.imem_ack && !id_stall));
        end
    endtask

    task automatic model_step();
        rec_t r;
        bit   had_held;
        had_held = (held.size() != 0);
        if (!m_idle && e_stall) m_stall_cnt++;
        if (flush) begin
            m_valid = 1'b0;
            m_instr = NOP_WORD;
            held.delete();
            if (m_idle) m_idle = 1'b0;
            else if (!had_held && !m_discard && !imem.imem_ack) begin
                m_discard  = 1'b1;
                m_old_addr = pc_in;
            end
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else if (had_held) begin
            if (!id_stall) begin
                r = held.pop_front();
                m_valid = 1'b1; m_pc = r.pc; m_instr = r.instr;
                m_fetch_cnt++;
            end
        end else if (m_discard) begin
            if (imem.imem_ack) m_discard = 1'b0;
        end else if (imem.imem_ack) begin
            r.pc = pc_in; r.instr = imem.imem_rdata;
            if (id_stall) held.push_back(r);
            else begin
                m_valid = 1'b1; m_pc = r.pc; m_instr = r.instr;
                m_fetch_cnt++;
            end
        end else if (!id_stall) begin
            m_valid = 1'b0;
            m_instr = NOP_WORD;
        end
        m_pc_reg = flush ? tgt : (e_stall ? m_pc_reg : m_pc_reg + 32'd4);
    endtask

    task automatic checkOutput();
        cmp("imem_req", {31'h0, imem.imem_req}, {31'h0, e_req});
        if (e_req) cmp("imem_addr", imem.imem_addr, e_addr);
        cmp("if_stall", {31'h0, if_stall}, {31'h0, e_stall});
        cmp("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
        cmp("id_instr", id_instr, m_valid ? m_instr : NOP_WORD);
        if (m_valid) begin
            cmp("id_pc", id_pc, m_pc);
            cmp("id_pc4", id_pc4, m_pc + 32'd4);
        end
`ifdef IF_FETCH_PERF_CNT_EN
        cmp("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
        cmp("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
`endif
    endtask

    task automatic applyStimulus(input bit ack, input bit ids, input bit fl, input logic [31:0] target);
        @(negedge clock);
        imem.imem_ack = ack;
        id_stall      = ids;
        flush         = fl;
        tgt           = target;
        pc_in         = m_pc_reg;
        compute_expected();
        imem.imem_rdata = e_req ? mem_word(e_addr) : 32'hDEAD_BEEF;
        #1;
        checkOutput();
        model_step();
    endtask

    task automatic check_reset_values(input string tag);
        cmp({tag, "_id_valid"}, {31'h0, id_valid}, 32'h0);
        cmp({tag, "_id_pc"}, id_pc, 32'h0);
        cmp({tag, "_id_pc4"}, id_pc4, 32'h0);
        cmp({tag, "_id_instr"}, id_instr, 32'h0);
        cmp({tag, "_imem_req"}, {31'h0, imem.imem_req}, 32'h0);
        cmp({tag, "_if_stall"}, {31'h0, if_stall}, 32'h1);
`ifdef IF_FETCH_PERF_CNT_EN
        cmp({tag, "_perf_fetch"}, perf_fetch_cnt, 32'h0);
        cmp({tag, "_perf_stall"}, perf_stall_cnt, 32'h0);
`endif
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 32'h0;
        model_reset(32'h0000_3000);
        pc_in = 32'h0000_3000;
        #12;
        check_reset_values("por");
        @(posedge clock);
        #2 reset = 1'b1;

        // zero-wait fetches from 0x3000
        applyStimulus(0, 0, 0, 0);               // c0 idle
        applyStimulus(1, 0, 0, 0);               // c1 fetch 0x3000
        applyStimulus(1, 0, 0, 0);               // c2 fetch 0x3004
        cmp("c2_id_valid", {31'h0, id_valid}, 32'h1);
        cmp("c2_id_pc", id_pc, 32'h0000_3000);
        cmp("c2_id_pc4", id_pc4, 32'h0000_3004);
        cmp("c2_id_instr", id_instr, 32'h5A5A_3000);
        cmp("c2_if_stall", {31'h0, if_stall}, 32'h0);

        // ack delayed three cycles at 0x3008
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0);
            cmp("wait_addr", imem.imem_addr, 32'h0000_3008);
            cmp("wait_if_stall", {31'h0, if_stall}, 32'h1);
        end
        cmp("wait_bubble", {31'h0, id_valid}, 32'h0);
        applyStimulus(1, 0, 0, 0);               // c6 ack 0x3008

        // decode stall as 0x300C returns
        applyStimulus(1, 1, 0, 0);               // c7 -> hold
        cmp("c7_id_pc", id_pc, 32'h0000_3008);
        cmp("c7_id_instr", id_instr, 32'h5A5A_3008);
        applyStimulus(0, 1, 0, 0);               // c8 hold
        cmp("c8_imem_req", {31'h0, imem.imem_req}, 32'h0);
        cmp("c8_id_pc", id_pc, 32'h0000_3008);
        applyStimulus(0, 0, 0, 0);               // c9 release
        applyStimulus(0, 0, 0, 0);               // c10
        cmp("c10_id_instr", id_instr, 32'h2408_0005);
        cmp("c10_id_pc", id_pc, 32'h0000_300C);

        // flush while 0x3010 is pending, redirect 0x3100
        applyStimulus(0, 0, 1, 32'h0000_3100);   // c11
        cmp("c11_if_stall", {31'h0, if_stall}, 32'h0);
        applyStimulus(0, 0, 0, 0);               // c12 drop
        cmp("c12_drop_addr", imem.imem_addr, 32'h0000_3010);
        cmp("c12_id_valid", {31'h0, id_valid}, 32'h0);
        applyStimulus(1, 0, 0, 0);               // c13 drop ack
        applyStimulus(1, 0, 0, 0);               // c14
        cmp("c14_redirect_addr", imem.imem_addr, 32'h0000_3100);

        // flush with ack and decode stall together
        applyStimulus(1, 1, 1, 32'h0000_3200);   // c15
        applyStimulus(0, 1, 0, 0);               // c16
        cmp("c16_id_valid", {31'h0, id_valid}, 32'h0);
        cmp("c16_id_instr", id_instr, 32'h0);
        cmp("c16_addr", imem.imem_addr, 32'h0000_3200);
        applyStimulus(1, 1, 0, 0);               // c17 -> hold
        applyStimulus(0, 1, 0, 0);               // c18 hold

        // asynchronous reset in HOLD
        #2 reset = 1'b0;
        #1;
        check_reset_values("hold_rst");
        model_reset(32'hFFFF_FFFC);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;

        // pc4 wrap, flush held in DROP, flush from HOLD
        applyStimulus(0, 0, 0, 0);               // c0 idle
        applyStimulus(1, 0, 0, 0);               // c1 fetch 0xFFFFFFFC
        applyStimulus(1, 0, 0, 0);               // c2 fetch 0x0
        cmp("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        cmp("wrap_id_pc4", id_pc4, 32'h0);
        applyStimulus(0, 0, 1, 32'h0000_0040);   // c3 -> drop
        applyStimulus(0, 0, 1, 32'h0000_0080);   // c4 flush in drop
        cmp("c4_drop_addr", imem.imem_addr, 32'h0000_0004);
        applyStimulus(1, 0, 0, 0);               // c5 drop ack
        applyStimulus(1, 0, 0, 0);               // c6 fetch 0x80
        applyStimulus(0, 0, 0, 0);               // c7 bubble
        applyStimulus(1, 1, 0, 0);               // c8 -> hold
        applyStimulus(0, 1, 1, 32'h0000_0200);   // c9 flush in hold
        applyStimulus(1, 0, 0, 0);               // c10
        cmp("c10_addr", imem.imem_addr, 32'h0000_0200);
        cmp("c10_id_valid", {31'h0, id_valid}, 32'h0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        cmp("end_id_pc", id_pc, 32'h0000_0204);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
